// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: turns a one-cycle
// start pulse into operand-latch, per-step enables and a result-ready strobe.
module multdiv_ctrl #(
    parameter int MULT_STEPS = 32,
    parameter int DIV_STEPS  = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    input  logic             mult_ovf,
    output logic             op_en,
    output logic             step_en,
    output logic             first_step,
    output logic             is_div,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             data_resultRDY,
    output logic             data_exception
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

    state_t           state;
    logic             exc_reg;
    logic             start;
    logic [CNT_W-1:0] last_idx;

    assign start    = (ctrl_MULT | ctrl_DIV) & ~clr;
    assign last_idx = is_div ? DIV_LAST : MULT_LAST;

    // A start is honoured in every state, so it also aborts a running op
    // and chains directly out of DONE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            count   <= '0;
            is_div  <= 1'b0;
            exc_reg <= 1'b0;
        end else if (start) begin
            count <= '0;
            if (ctrl_MULT) begin
                state   <= RUN;
                is_div  <= 1'b0;
                exc_reg <= 1'b0;
            end else if (divisor_zero) begin
                state   <= DONE;
                is_div  <= 1'b1;
                exc_reg <= 1'b1;
            end else begin
                state   <= RUN;
                is_div  <= 1'b1;
                exc_reg <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (count == last_idx) begin
                        state   <= DONE;
                        exc_reg <= ~is_div & mult_ovf;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // All outputs other than op_en are pure decodes of registered state.
    assign op_en          = start;
    assign step_en        = (state == RUN);
    assign busy           = (state == RUN);
    assign first_step     = (state == RUN) && (count == '0);
    assign data_resultRDY = (state == DONE);
    assign data_exception = (state == DONE) & exc_reg;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed scenarios plus random traffic, checked
// every cycle against a timeline model indexed by cycles since the last start.
module tb_multdiv_ctrl;

    localparam int MULT_STEPS = 32;
    localparam int DIV_STEPS  = 32;
    localparam int CNT_W      = 6;

    logic             clk;
    logic             clr;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             divisor_zero;
    logic             mult_ovf;
    logic             op_en;
    logic             step_en;
    logic             first_step;
    logic             is_div;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             data_resultRDY;
    logic             data_exception;

    multdiv_ctrl #(
        .MULT_STEPS(MULT_STEPS),
        .DIV_STEPS (DIV_STEPS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .divisor_zero  (divisor_zero),
        .mult_ovf      (mult_ovf),
        .op_en         (op_en),
        .step_en       (step_en),
        .first_step    (first_step),
        .is_div        (is_div),
        .count         (count),
        .busy          (busy),
        .data_resultRDY(data_resultRDY),
        .data_exception(data_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdy_seen = 0;

    // Reference model: the last accepted operation and when it started.
    bit m_valid    = 1'b0;
    int m_start    = 0;
    bit m_div      = 1'b0;
    bit m_dz       = 1'b0;
    bit m_ovf      = 1'b0;
    bit m_isdiv    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all(input bit m, input bit d, input bit cl);
        int  k, n;
        bit  e_step, e_first, e_rdy, e_exc;
        int  e_cnt;
        k = cyc - m_start;
        n = m_div ? DIV_STEPS : MULT_STEPS;
        e_step = 0; e_first = 0; e_rdy = 0; e_exc = 0; e_cnt = 0;
        if (m_valid && m_dz && k == 1) begin
            e_rdy = 1; e_exc = 1;
        end else if (m_valid && !m_dz && k >= 1 && k <= n) begin
            e_step = 1; e_first = (k == 1); e_cnt = k - 1;
        end else if (m_valid && !m_dz && k == n + 1) begin
            e_rdy = 1; e_exc = m_div ? 1'b0 : m_ovf; e_cnt = n - 1;
        end
        check("op_en",      32'(op_en),          32'((m | d) & ~cl));
        check("step_en",    32'(step_en),        32'(e_step));
        check("busy",       32'(busy),           32'(e_step));
        check("first_step", 32'(first_step),     32'(e_first));
        check("count",      32'(count),          32'(e_cnt));
        check("is_div",     32'(is_div),         32'(m_isdiv));
        check("result_rdy", 32'(data_resultRDY), 32'(e_rdy));
        check("exception",  32'(data_exception), 32'(e_exc));
        if (data_resultRDY === 1'b1) rdy_seen++;
    endtask

    task automatic model_update(input bit m, input bit d, input bit dz, input bit ov, input bit cl);
        if (m_valid && !m_dz && !m_div && (cyc - m_start) == MULT_STEPS)
            m_ovf = ov;
        if (cl) begin
            m_valid = 0;
            m_isdiv = 0;
        end else if (m | d) begin
            m_valid = 1;
            m_start = cyc;
            m_div   = !m && d;
            m_dz    = m_div && dz;
            m_ovf   = 0;
            m_isdiv = m_div;
        end
    endtask

    // One clock cycle: drive inputs just after the edge, check, advance model.
    task automatic step(input bit m, input bit d, input bit dz, input bit ov, input bit cl);
        @(posedge clk);
        #1;
        cyc++;
        ctrl_MULT    = m;
        ctrl_DIV     = d;
        divisor_zero = dz;
        mult_ovf     = ov;
        clr          = cl;
        #1;
        check_all(m, d, cl);
        model_update(m, d, dz, ov, cl);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int r0;
        clr = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        divisor_zero = 1'b0; mult_ovf = 1'b0;
        repeat (2) @(posedge clk);

        // reset held with a multiply pulse present
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        idle(3);

        // plain multiply
        step(1, 0, 0, 0, 0);
        idle(40);

        // multiply with overflow on the final step, then on an early step
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) step(0, 0, 0, i == 32, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 1; i <= 40; i++) step(0, 0, 0, i == 10, 0);

        // divide by zero, and a normal divide
        step(0, 1, 1, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0);
        idle(40);

        // abort a multiply with a divide; exactly one result strobe follows
        r0 = rdy_seen;
        step(1, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0);
        idle(40);
        check("abort_rdy_count", 32'(rdy_seen - r0), 32'd1);

        // both starts together: multiply wins
        step(1, 1, 1, 0, 0);
        idle(40);

        // start while DONE chains straight into the next op
        step(1, 0, 0, 0, 0);
        idle(32);
        step(0, 1, 0, 0, 0);
        idle(40);

        // clear in the middle of a multiply: no result strobe
        r0 = rdy_seen;
        step(1, 0, 0, 0, 0);
        idle(19);
        step(0, 0, 0, 0, 1);
        idle(40);
        check("clr_rdy_count", 32'(rdy_seen - r0), 32'd0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bit m, d, dz, ov, cl;
            m  = ($urandom_range(0, 24) == 0);
            d  = ($urandom_range(0, 24) == 0);
            dz = ($urandom_range(0, 2) == 0);
            ov = $urandom_range(0, 1);
            cl = ($urandom_range(0, 99) == 0);
            step(m, d, dz, ov, cl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
